// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared encodings and defaults for the iterative mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int unsigned c_DEFAULT_WIDTH = 32;
    localparam int unsigned c_DEFAULT_CNT_W = 6;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_DIVU  = 2'b01,
        OP_MULT  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One radix-2 iteration: shift-add multiply or restoring
//               shift-subtract divide on the {acc, q} register pair.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sum   = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        w_shift = {acc, q[WIDTH-1]};
        w_diff  = w_shift - {1'b0, m};
        if (div) begin
            // A borrow out of the (WIDTH+1)-bit subtract means divisor did not fit
            if (w_diff[WIDTH]) begin
                acc_nxt = w_shift[WIDTH-1:0];
                q_nxt   = {q[WIDTH-2:0], 1'b0};
            end else begin
                acc_nxt = w_diff[WIDTH-1:0];
                q_nxt   = {q[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_nxt = w_sum[WIDTH:1];
            q_nxt   = {w_sum[0], q[WIDTH-1:1]};
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multicycle HI/LO multiply/divide unit with busy/done stall
//               handshake. Signed MULT/DIV enabled by MULDIV_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEFAULT_WIDTH,
    parameter int unsigned CNT_W = c_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_is_div;
    logic             w_div_zero;
    logic             w_last;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_hi_res;
    logic [WIDTH-1:0] w_lo_res;

`ifdef MULDIV_SIGNED_EN
    logic               r_neg_q;
    logic               r_neg_r;
    logic               w_is_signed;
    logic               w_neg_q_nxt;
    logic               w_neg_r_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
`endif

    assign w_is_div   = (op == OP_DIVU) || (op == OP_DIV);
    assign w_div_zero = w_is_div && (b == '0);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .div     (r_div),
        .acc     (r_acc),
        .q       (r_q),
        .m       (r_m),
        .acc_nxt (w_acc_nxt),
        .q_nxt   (w_q_nxt)
    );

    // Operand magnitudes on the way in, sign fixup on the final step result
    always_comb begin
        w_mag_a  = a;
        w_mag_b  = b;
        w_hi_res = w_acc_nxt;
        w_lo_res = w_q_nxt;
`ifdef MULDIV_SIGNED_EN
        w_is_signed = (op == OP_MULT) || (op == OP_DIV);
        w_neg_q_nxt = w_is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        w_neg_r_nxt = w_is_signed && a[WIDTH-1];
        if (w_is_signed && a[WIDTH-1]) w_mag_a = -a;
        if (w_is_signed && b[WIDTH-1]) w_mag_b = -b;
        w_prod   = {w_acc_nxt, w_q_nxt};
        w_prod_s = r_neg_q ? -w_prod : w_prod;
        if (r_div) begin
            w_hi_res = r_neg_r ? -w_acc_nxt : w_acc_nxt;
            w_lo_res = r_neg_q ? -w_q_nxt   : w_q_nxt;
        end else begin
            w_hi_res = w_prod_s[2*WIDTH-1:WIDTH];
            w_lo_res = w_prod_s[WIDTH-1:0];
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = w_div_zero ? ST_DONE : ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_div   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef MULDIV_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_div <= w_is_div;
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_q   <= w_is_div ? w_mag_a : w_mag_b;
                        r_m   <= w_is_div ? w_mag_b : w_mag_a;
`ifdef MULDIV_SIGNED_EN
                        r_neg_q <= w_neg_q_nxt;
                        r_neg_r <= w_neg_r_nxt;
`endif
                        if (w_div_zero) begin
                            r_hi <= a;
                            r_lo <= '1;
                        end
                    end else begin
                        if (mthi) r_hi <= a;
                        if (mtlo) r_lo <= a;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi <= w_hi_res;
                        r_lo <= w_lo_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit (signed vectors
//               follow MULDIV_SIGNED_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        r_rst;
    logic        r_start;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_mthi;
    logic        r_mtlo;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic        w_busy;
    logic        w_done;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .rst   (r_rst),
        .start (r_start),
        .op    (r_op),
        .a     (r_a),
        .b     (r_b),
        .mthi  (r_mthi),
        .mtlo  (r_mtlo),
        .hi    (w_hi),
        .lo    (w_lo),
        .busy  (w_busy),
        .done  (w_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation, then scramble a/b to prove they were captured
    task automatic run_op(input string tag, input logic [1:0] op_i,
                          input logic [31:0] a_i, input logic [31:0] b_i,
                          input int lat_exp);
        int  n;
        int  nbusy;
        bit  seen;
        @(negedge clk);
        r_start = 1'b1; r_op = op_i; r_a = a_i; r_b = b_i;
        @(negedge clk);
        r_start = 1'b0; r_a = ~a_i; r_b = ~b_i; r_op = ~op_i;
        n = 1; nbusy = 0; seen = 1'b0;
        while (!seen && n <= 100) begin
            if (w_busy) nbusy++;
            if (w_done) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check({tag, ":latency"}, seen ? n : 0, lat_exp);
        check({tag, ":busy_cycles"}, nbusy, lat_exp);
        @(negedge clk);
        check({tag, ":done_pulse"}, {w_done, w_busy}, 2'b00);
    endtask

    initial begin
        int  n;
        bit  seen;
        int  pulses;

        r_rst = 1'b1; r_start = 1'b0; r_op = 2'b00;
        r_a = '0; r_b = '0; r_mthi = 1'b0; r_mtlo = 1'b0;
        repeat (2) @(negedge clk);
        r_rst = 1'b0;
        check("reset_state", {w_hi, w_lo, 30'd0, w_busy, w_done}, 64'd0 << 0);
        check("reset_hilo", {w_hi, w_lo}, 64'd0);

        run_op("multu_7x6", OP_MULTU, 32'h0000_0007, 32'h0000_0006, 33);
        check("multu_7x6", {w_hi, w_lo}, 64'h0000_0000_0000_002A);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        check("multu_max", {w_hi, w_lo}, 64'hFFFF_FFFE_0000_0001);

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33);
        check("divu_100_7", {w_hi, w_lo}, {32'd2, 32'd14});

        run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 1);
        check("divu_by0", {w_hi, w_lo}, {32'd5, 32'hFFFF_FFFF});

        // Moves: both at once, then separately
        @(negedge clk);
        r_a = 32'h0000_ABCD; r_mthi = 1'b1; r_mtlo = 1'b1;
        @(negedge clk);
        r_mthi = 1'b0; r_mtlo = 1'b0;
        check("mthi_mtlo_same", {w_hi, w_lo}, {32'h0000_ABCD, 32'h0000_ABCD});
        r_a = 32'h0000_1234; r_mthi = 1'b1;
        @(negedge clk);
        r_mthi = 1'b0; r_a = 32'h0000_5678; r_mtlo = 1'b1;
        @(negedge clk);
        r_mtlo = 1'b0;
        check("mthi_mtlo_seq", {w_hi, w_lo}, {32'h0000_1234, 32'h0000_5678});

        // Start with a simultaneous mthi, then mthi again mid-run with a new a
        r_start = 1'b1; r_op = OP_DIVU; r_a = 32'd1000; r_b = 32'd7; r_mthi = 1'b1;
        @(negedge clk);
        r_start = 1'b0; r_mthi = 1'b0;
        check("start_beats_mthi", {w_hi, w_lo}, {32'h0000_1234, 32'h0000_5678});
        repeat (4) @(negedge clk);
        r_mthi = 1'b1; r_mtlo = 1'b1; r_a = 32'h0000_DEAD;
        @(negedge clk);
        r_mthi = 1'b0; r_mtlo = 1'b0;
        check("hold_during_run", {w_hi, w_lo}, {32'h0000_1234, 32'h0000_5678});
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            if (w_done) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check("divu_1000_7_done", seen, 1'b1);
        check("divu_1000_7", {w_hi, w_lo}, {32'd6, 32'd142});
        @(negedge clk);

        // Reset in the middle of a multiply
        r_start = 1'b1; r_op = OP_MULTU; r_a = 32'h0000_1234; r_b = 32'h0000_0010;
        @(negedge clk);
        r_start = 1'b0;
        repeat (9) @(negedge clk);
        r_rst = 1'b1;
        @(negedge clk);
        r_rst = 1'b0;
        check("abort_state", {w_hi, w_lo}, 64'd0);
        check("abort_flags", {w_busy, w_done}, 2'b00);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (w_done || w_busy) pulses++;
        end
        check("abort_no_done", pulses, 0);

        run_op("multu_3x3", OP_MULTU, 32'd3, 32'd3, 33);
        check("multu_3x3", {w_hi, w_lo}, 64'd9);

`ifdef MULDIV_SIGNED_EN
        run_op("mult_m3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 33);
        check("mult_m3x5", {w_hi, w_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33);
        check("div_m7_2", {w_hi, w_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 33);
        check("div_7_m2", {w_hi, w_lo}, {32'd1, 32'hFFFF_FFFD});
        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33);
        check("div_min_m1", {w_hi, w_lo}, {32'd0, 32'h8000_0000});
`else
        run_op("mult_m3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 33);
        check("mult_m3x5", {w_hi, w_lo}, 64'h0000_0004_FFFF_FFF1);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33);
        check("div_m7_2", {w_hi, w_lo}, {32'd1, 32'h7FFF_FFFC});
        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33);
        check("div_min_m1", {w_hi, w_lo}, {32'h8000_0000, 32'd0});
`endif

        run_op("div_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 1);
        check("div_by0", {w_hi, w_lo}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_muldiv_unit
`default_nettype wire
